// File: rtl/ahb_resp_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : ahb_resp_mux_n
// Description : AHB-Lite data-phase response multiplexer. Registers the
//               address-phase slave select on each HREADY-qualified edge, holds
//               it through the data phase, and AND-OR muxes read data, ready and
//               response from NSLV slaves onto the master side. A built-in
//               default slave answers unmapped NONSEQ/SEQ accesses with a
//               two-cycle ERROR, and non-one-hot selects raise a one-cycle flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   HCLK           in   1        system clock
//   HRESETn        in   1        asynchronous active-low reset
//   hsel_vec       in   NSLV     address-phase slave selects (bit i = slave i)
//   htrans         in   2        address-phase HTRANS from the master
//   slv_hrdata     in   NSLV*DW  flattened slave read data, slave i at [i*DW +: DW]
//   slv_hreadyout  in   NSLV     per-slave HREADYOUT
//   slv_hresp      in   NSLV     per-slave HRESP (1 = ERROR)
//   hrdata         out  DW       muxed read data
//   hready         out  1        muxed HREADY to the master and all slaves
//   hresp          out  1        muxed HRESP
//   onehot_err     out  1        one-cycle pulse on a non-one-hot capture
// ============================================================================
module ahb_resp_mux_n #(
    parameter int NSLV = 24,
    parameter int DW   = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NSLV-1:0]    hsel_vec,
    input  logic [1:0]         htrans,
    input  logic [NSLV*DW-1:0] slv_hrdata,
    input  logic [NSLV-1:0]    slv_hreadyout,
    input  logic [NSLV-1:0]    slv_hresp,
    output logic [DW-1:0]      hrdata,
    output logic               hready,
    output logic               hresp,
    output logic               onehot_err
);

    localparam logic [1:0] c_DS_IDLE = 2'd0;
    localparam logic [1:0] c_DS_ERR1 = 2'd1;
    localparam logic [1:0] c_DS_ERR2 = 2'd2;

    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    logic [NSLV-1:0] r_dsel;
    logic [1:0]      r_ds_state;
    logic [1:0]      w_ds_next;
    logic            r_onehot_err;

    logic [NSLV-1:0] w_sel_pri;
    logic            w_multi_hot;
    logic            w_unmapped;

    // x & -x isolates the lowest set bit, giving lowest-index priority.
    assign w_sel_pri   = hsel_vec & (~hsel_vec + NSLV'(1));
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi_hot = |(hsel_vec & (hsel_vec - NSLV'(1)));
    assign w_unmapped  = (hsel_vec == '0) &&
                         ((htrans == c_HTRANS_NONSEQ) || (htrans == c_HTRANS_SEQ));

    // Select / flag capture: only on edges where the bus is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel       <= '0;
            r_onehot_err <= 1'b0;
        end else begin
            if (hready) begin
                r_dsel <= w_sel_pri;
            end
            r_onehot_err <= hready & w_multi_hot;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ds_state <= c_DS_IDLE;
        end else begin
            r_ds_state <= w_ds_next;
        end
    end

    // ERR1 advances regardless of hready (it is the wait cycle it creates);
    // IDLE only moves on a real capture; ERR2 always has hready = 1.
    always_comb begin
        w_ds_next = r_ds_state;
        case (r_ds_state)
            c_DS_IDLE: begin
                if (hready && w_unmapped) begin
                    w_ds_next = c_DS_ERR1;
                end
            end
            c_DS_ERR1: w_ds_next = c_DS_ERR2;
            c_DS_ERR2: w_ds_next = w_unmapped ? c_DS_ERR1 : c_DS_IDLE;
            default:   w_ds_next = c_DS_IDLE;
        endcase
    end

    // Output mux driven purely from registered state and slave responses.
    // A non-zero dsel and a non-idle default slave never coexist.
    always_comb begin
        hrdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            hrdata = hrdata | (slv_hrdata[i*DW +: DW] & {DW{r_dsel[i]}});
        end

        if (r_dsel != '0) begin
            hready = |(r_dsel & slv_hreadyout);
        end else if (r_ds_state == c_DS_ERR1) begin
            hready = 1'b0;
        end else begin
            hready = 1'b1;
        end

        hresp = (|(r_dsel & slv_hresp)) ||
                (r_ds_state == c_DS_ERR1) || (r_ds_state == c_DS_ERR2);
    end

    assign onehot_err = r_onehot_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_resp_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_resp_mux_n
// Description : Self-checking bench for ahb_resp_mux_n (NSLV = 24, DW = 32).
//               A table of per-cycle vectors supplies address-phase and
//               data-phase inputs together with hand-computed outputs for that
//               same cycle; an extra sequence covers reset during DS_ERR1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_resp_mux_n;

    localparam int NSLV  = 24;
    localparam int DW    = 32;
    localparam int NVEC  = 18;

    logic               HCLK;
    logic               HRESETn;
    logic [NSLV-1:0]    hsel_vec;
    logic [1:0]         htrans;
    logic [NSLV*DW-1:0] slv_hrdata;
    logic [NSLV-1:0]    slv_hreadyout;
    logic [NSLV-1:0]    slv_hresp;
    logic [DW-1:0]      hrdata;
    logic               hready;
    logic               hresp;
    logic               onehot_err;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [NSLV-1:0] hsel;
        logic [1:0]      trans;
        logic [NSLV-1:0] rdy;
        logic [NSLV-1:0] resp;
        logic [DW-1:0]   exp_rdata;
        logic            exp_ready;
        logic            exp_resp;
        logic            exp_oh;
    } vec_t;

    vec_t vecs [NVEC];

    ahb_resp_mux_n #(
        .NSLV (NSLV),
        .DW   (DW)
    ) u_dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .hsel_vec      (hsel_vec),
        .htrans        (htrans),
        .slv_hrdata    (slv_hrdata),
        .slv_hreadyout (slv_hreadyout),
        .slv_hresp     (slv_hresp),
        .hrdata        (hrdata),
        .hready        (hready),
        .hresp         (hresp),
        .onehot_err    (onehot_err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic vec_t mk(input logic [NSLV-1:0] hsel, input logic [1:0] trans,
                                input logic [NSLV-1:0] rdy, input logic [NSLV-1:0] resp,
                                input logic [DW-1:0] rd, input logic rdyo,
                                input logic rsp, input logic oh);
        vec_t v;
        v.hsel = hsel; v.trans = trans; v.rdy = rdy; v.resp = resp;
        v.exp_rdata = rd; v.exp_ready = rdyo; v.exp_resp = rsp; v.exp_oh = oh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [DW-1:0] rd, input logic rdy,
                           input logic rsp, input logic oh);
        chk({tag, " hrdata"},     hrdata,             rd);
        chk({tag, " hready"},     {31'd0, hready},    {31'd0, rdy});
        chk({tag, " hresp"},      {31'd0, hresp},     {31'd0, rsp});
        chk({tag, " onehot_err"}, {31'd0, onehot_err}, {31'd0, oh});
    endtask

    localparam logic [NSLV-1:0] ALL1 = '1;
    localparam logic [NSLV-1:0] NONE = '0;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Slave 17 carries the marker word; every other slave a distinct value.
        for (int i = 0; i < NSLV; i++) begin
            slv_hrdata[i*DW +: DW] = 32'h1000_0000 + 32'(i);
        end
        slv_hrdata[17*DW +: DW] = 32'hA5A5_0017;

        // Each row: inputs held during this cycle, outputs expected in this cycle.
        // Outputs reflect the select captured at the end of the previous row.
        vecs[0]  = mk(NONE,     2'b00, ALL1, NONE, 32'h0,          1, 0, 0); // reset state
        vecs[1]  = mk(24'h1<<17, 2'b10, ALL1, NONE, 32'h0,         1, 0, 0); // idle unmapped before
        vecs[2]  = mk(NONE,     2'b00, ALL1, NONE, 32'hA5A5_0017,  1, 0, 0); // basic read slave 17
        vecs[3]  = mk(24'h1<<3, 2'b10, ALL1, NONE, 32'h0,          1, 0, 0);
        vecs[4]  = mk(24'h1<<9, 2'b10, ~(24'h1<<3), NONE, 32'h1000_0003, 0, 0, 0); // wait 1
        vecs[5]  = mk(24'h1<<5, 2'b10, ~(24'h1<<3), NONE, 32'h1000_0003, 0, 0, 0); // wait 2
        vecs[6]  = mk(24'h1<<5, 2'b10, ALL1, NONE, 32'h1000_0003,  1, 0, 0); // capture slave 5
        vecs[7]  = mk(NONE,     2'b11, ALL1, NONE, 32'h1000_0005,  1, 0, 0); // slave 5 data, unmapped SEQ
        vecs[8]  = mk(NONE,     2'b11, ALL1, NONE, 32'h0,          0, 1, 0); // ERR1
        vecs[9]  = mk(NONE,     2'b11, ALL1, NONE, 32'h0,          1, 1, 0); // ERR2, unmapped again
        vecs[10] = mk(24'h1<<6, 2'b10, ALL1, NONE, 32'h0,          0, 1, 0); // ERR1 (select ignored)
        vecs[11] = mk(24'h0C0,  2'b10, ALL1, NONE, 32'h0,          1, 1, 0); // ERR2, capture bits 6+7
        vecs[12] = mk(NONE,     2'b00, ALL1, 24'h1<<7, 32'h1000_0006, 1, 0, 1); // slave 6 only, flag
        vecs[13] = mk(24'h1<<2, 2'b10, ALL1, NONE, 32'h0,          1, 0, 0); // flag gone
        vecs[14] = mk(NONE,     2'b00, ~(24'h1<<2), 24'h1<<2, 32'h1000_0002, 0, 1, 0); // slave ERR c1
        vecs[15] = mk(NONE,     2'b00, ALL1, 24'h1<<2, 32'h1000_0002, 1, 1, 0); // slave ERR c2
        vecs[16] = mk(NONE,     2'b01, ALL1, NONE, 32'h0,          1, 0, 0); // BUSY unmapped
        vecs[17] = mk(NONE,     2'b00, ALL1, NONE, 32'h0,          1, 0, 0); // stays OKAY

        HRESETn       = 1'b0;
        hsel_vec      = '0;
        htrans        = 2'b00;
        slv_hreadyout = '1;
        slv_hresp     = '0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            @(posedge HCLK);
            #1;
            hsel_vec      = vecs[k].hsel;
            htrans        = vecs[k].trans;
            slv_hreadyout = vecs[k].rdy;
            slv_hresp     = vecs[k].resp;
            @(negedge HCLK);
            chk_all($sformatf("vec%0d", k), vecs[k].exp_rdata, vecs[k].exp_ready,
                    vecs[k].exp_resp, vecs[k].exp_oh);
        end

        // Asynchronous reset while the default slave sits in DS_ERR1.
        @(posedge HCLK);
        #1;
        hsel_vec = '0;
        htrans   = 2'b10;
        @(posedge HCLK);
        #1;
        htrans = 2'b00;
        @(negedge HCLK);
        chk_all("err1_before_rst", 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        chk_all("after_rst_idle", 32'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
